alsu_cmd_sequencer: RTL and testbench

- Upstream feeder for the ALSU.
- Accepts ALSU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALSU's registered input ports one vector per cycle, expanding shift/rotate commands into repeated steps.
- Captures the ALSU's 6-bit out after the fixed pipeline latency and reports one result per command, plus an error flag for encodings the ALSU treats as invalid.

---
 rtl/alsu_pkg.sv | 64 ++++++
 rtl/alsu_cmd_fifo.sv | 73 +++++++
 rtl/alsu_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alsu_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// ---------------------------------------------------------------------------
// alsu_pkg
// Shared types for the ALSU command sequencer slice.
//   opcode_e     : ALSU opcode encodings (110/111 are invalid on the ALSU)
//   seq_state_e  : sequencer FSM states
//   alsu_cmd_t   : one buffered command, every cmd_* field of the upstream port
//   step_tag_t   : per-driven-vector tag carried alongside the ALSU pipeline
//   PARK_CMD     : all-zero vector (OR of 0,0 -> ALSU out 0)
//   is_invalid() : encodings the ALSU refuses to compute
//   is_shift()   : opcodes that expand into repeated steps
// ---------------------------------------------------------------------------
package alsu_pkg;

    typedef enum logic [2:0] {
        OR     = 3'b000,
        XOR    = 3'b001,
        ADD    = 3'b010,
        MULT   = 3'b011,
        SHIFT  = 3'b100,
        ROTATE = 3'b101,
        INV6   = 3'b110,
        INV7   = 3'b111
    } opcode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       red_a;
        logic       red_b;
        logic       byp_a;
        logic       byp_b;
        logic       dir;
        logic [2:0] rep;
    } alsu_cmd_t;

    typedef struct packed {
        logic last;
        logic err;
    } step_tag_t;

    localparam alsu_cmd_t PARK_CMD = '0;

    // Reduction is only meaningful for the two bitwise opcodes; anything
    // else asking for it, or the two unused opcodes, is rejected by the ALSU.
    function automatic logic is_invalid(alsu_cmd_t cmd);
        logic red_any;
        red_any = cmd.red_a | cmd.red_b;
        return (cmd.opcode == INV6) || (cmd.opcode == INV7) ||
               (red_any && (cmd.opcode != OR) && (cmd.opcode != XOR));
    endfunction

    function automatic logic is_shift(alsu_cmd_t cmd);
        return (cmd.opcode == SHIFT) || (cmd.opcode == ROTATE);
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alsu_cmd_fifo
// Synchronous FIFO of alsu_cmd_t with count-based full/empty flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data (ignored when full)
//   wr_data    : command to enqueue
//   pop        : drop the head entry (ignored when empty)
//   rd_data    : current head entry (valid when !empty)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module alsu_cmd_fifo
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  alsu_cmd_t wr_data,
    input  logic      pop,
    output alsu_cmd_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    alsu_cmd_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count
    // alone decides full/empty so no extra wrap bit is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alsu_cmd_sequencer
// Buffers ALSU commands and drives the ALSU one registered vector per cycle,
// repeating shift/rotate vectors (cmd_rep+1 times), then reports one result
// per command after the ALSU pipeline latency.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake (ready = FIFO not full)
//   cmd_*             : command fields
//   alsu_*            : registered drive vector into the ALSU
//   alsu_out          : ALSU result, ALSU_LAT cycles after the drive cycle
//   res_valid/data/err: one-cycle result strobe, sampled result, invalid flag
//   busy              : queued, issuing, or awaiting a result
// ---------------------------------------------------------------------------
module alsu_cmd_sequencer
    import alsu_pkg::*;
#(
    parameter int    FIFO_DEPTH     = 4,
    parameter int    ALSU_LAT       = 2,
    parameter string INPUT_PRIORITY = "A"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    input  logic       cmd_cin,
    input  logic       cmd_serial_in,
    input  logic       cmd_red_a,
    input  logic       cmd_red_b,
    input  logic       cmd_byp_a,
    input  logic       cmd_byp_b,
    input  logic       cmd_dir,
    input  logic [2:0] cmd_rep,
    output logic [2:0] alsu_a,
    output logic [2:0] alsu_b,
    output logic [2:0] alsu_opcode,
    output logic       alsu_cin,
    output logic       alsu_serial_in,
    output logic       alsu_red_a,
    output logic       alsu_red_b,
    output logic       alsu_byp_a,
    output logic       alsu_byp_b,
    output logic       alsu_dir,
    input  logic [5:0] alsu_out,
    output logic       res_valid,
    output logic [5:0] res_data,
    output logic       res_err,
    output logic       busy
);

    // The sequencer never computes results itself; the priority only has to
    // name one of the two operands the ALSU understands.
    if (!(INPUT_PRIORITY == "A" || INPUT_PRIORITY == "B")) begin : g_bad_priority
        $error("INPUT_PRIORITY must be \"A\" or \"B\"");
    end

    alsu_cmd_t  cmd_in;
    alsu_cmd_t  head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    seq_state_e state_q, state_d;
    logic [2:0] steps_q, steps_d;
    alsu_cmd_t  drive_q, drive_d;
    logic       err_q, err_d;
    logic       take_head;

    step_tag_t  cur_tag;
    step_tag_t  tag_pipe [ALSU_LAT];
    logic       pipe_busy;

    assign cmd_in = '{opcode: opcode_e'(cmd_opcode), a: cmd_a, b: cmd_b, cin: cmd_cin,
                      serial_in: cmd_serial_in, red_a: cmd_red_a, red_b: cmd_red_b,
                      byp_a: cmd_byp_a, byp_b: cmd_byp_b, dir: cmd_dir, rep: cmd_rep};

    alsu_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (cmd_valid),
        .wr_data(cmd_in),
        .pop    (pop),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    // FSM state, step counter, drive vector and the error flag of the
    // command currently being driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            steps_q <= '0;
            drive_q <= PARK_CMD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            drive_q <= drive_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. The head is taken either from IDLE or on the last
    // step of the current command, so consecutive commands issue with no
    // bubble; anything else falls back to the park vector.
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        drive_d   = PARK_CMD;
        err_d     = err_q;
        take_head = 1'b0;
        case (state_q)
            IDLE: begin
                take_head = !fifo_empty;
            end
            ISSUE: begin
                if (steps_q != 3'd0) begin
                    steps_d = steps_q - 3'd1;
                    drive_d = drive_q;
                end else if (!fifo_empty) begin
                    take_head = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take_head) begin
            state_d = ISSUE;
            drive_d = head;
            steps_d = is_shift(head) ? head.rep : 3'd0;
            err_d   = is_invalid(head);
        end
    end

    assign pop = take_head;

    assign alsu_opcode    = drive_q.opcode;
    assign alsu_a         = drive_q.a;
    assign alsu_b         = drive_q.b;
    assign alsu_cin       = drive_q.cin;
    assign alsu_serial_in = drive_q.serial_in;
    assign alsu_red_a     = drive_q.red_a;
    assign alsu_red_b     = drive_q.red_b;
    assign alsu_byp_a     = drive_q.byp_a;
    assign alsu_byp_b     = drive_q.byp_b;
    assign alsu_dir       = drive_q.dir;

    // Only the final step of a command wants its result reported.
    assign cur_tag.last = (state_q == ISSUE) && (steps_q == 3'd0);
    assign cur_tag.err  = err_q;

    // The tag follows its vector through the ALSU; when it reaches the last
    // stage alsu_out holds that vector's result, which is captured into the
    // result register (the final pipe stage) together with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALSU_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            tag_pipe[0] <= cur_tag;
            for (int i = 1; i < ALSU_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            res_valid <= tag_pipe[ALSU_LAT-1].last;
            res_err   <= tag_pipe[ALSU_LAT-1].last & tag_pipe[ALSU_LAT-1].err;
            if (tag_pipe[ALSU_LAT-1].last) begin
                res_data <= alsu_out;
            end
        end
    end

    // Any result still on its way keeps the block busy.
    always_comb begin
        pipe_busy = res_valid;
        for (int i = 0; i < ALSU_LAT; i++) begin
            pipe_busy = pipe_busy | tag_pipe[i].last;
        end
    end

    assign busy = !fifo_empty || (state_q != IDLE) || pipe_busy;

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alsu_cmd_sequencer
// Bench for alsu_cmd_sequencer with a behavioural ALSU attached to its drive
// port and a transaction-level schedule model predicting drive vectors,
// cmd_ready and results.
// ---------------------------------------------------------------------------
module tb_alsu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic       serial_in;
        logic       red_a;
        logic       red_b;
        logic       byp_a;
        logic       byp_b;
        logic       dir;
        logic [2:0] rep;
    } tb_cmd_t;

    // One accepted command: the cycle it is taken from the FIFO, its drive
    // window and the result/error it must report.
    typedef struct {
        tb_cmd_t    cmd;
        int         d;
        int         first;
        int         last;
        logic [5:0] res;
        logic       err;
    } sched_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    tb_cmd_t    cur_cmd = '0;
    logic       cmd_ready;
    logic [2:0] alsu_a, alsu_b, alsu_opcode;
    logic       alsu_cin, alsu_serial_in, alsu_red_a, alsu_red_b;
    logic       alsu_byp_a, alsu_byp_b, alsu_dir;
    logic [5:0] alsu_out;
    logic       res_valid;
    logic [5:0] res_data;
    logic       res_err;
    logic       busy;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    sched_t     sched [$];
    int         last_drive = -100;
    logic [5:0] last_res = '0;

    tb_cmd_t    env_in;
    tb_cmd_t    drv_cmd;
    logic [15:0] dut_vec;

    alsu_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .ALSU_LAT(LAT),
        .INPUT_PRIORITY("A")
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cur_cmd.opcode),
        .cmd_a         (cur_cmd.a),
        .cmd_b         (cur_cmd.b),
        .cmd_cin       (cur_cmd.cin),
        .cmd_serial_in (cur_cmd.serial_in),
        .cmd_red_a     (cur_cmd.red_a),
        .cmd_red_b     (cur_cmd.red_b),
        .cmd_byp_a     (cur_cmd.byp_a),
        .cmd_byp_b     (cur_cmd.byp_b),
        .cmd_dir       (cur_cmd.dir),
        .cmd_rep       (cur_cmd.rep),
        .alsu_a        (alsu_a),
        .alsu_b        (alsu_b),
        .alsu_opcode   (alsu_opcode),
        .alsu_cin      (alsu_cin),
        .alsu_serial_in(alsu_serial_in),
        .alsu_red_a    (alsu_red_a),
        .alsu_red_b    (alsu_red_b),
        .alsu_byp_a    (alsu_byp_a),
        .alsu_byp_b    (alsu_byp_b),
        .alsu_dir      (alsu_dir),
        .alsu_out      (alsu_out),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_err       (res_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    assign drv_cmd = {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_red_a,
                      alsu_red_b, alsu_byp_a, alsu_byp_b, alsu_dir, 3'b000};
    assign dut_vec = drv_cmd[18:3];

    // Encodings the ALSU refuses: unused opcodes, or reduction outside OR/XOR.
    function automatic logic bad_encoding(tb_cmd_t c);
        if (c.opcode == 3'd6 || c.opcode == 3'd7) return 1'b1;
        return (c.red_a || c.red_b) && (c.opcode > 3'd1);
    endfunction

    // Behavioural ALSU: one vector applied to the previous output.
    function automatic logic [5:0] alsu_f(tb_cmd_t c, logic [5:0] prev);
        if (c.byp_a) return {3'b000, c.a};
        if (c.byp_b) return {3'b000, c.b};
        if (bad_encoding(c)) return 6'd0;
        case (c.opcode)
            3'd0: return c.red_a ? {5'd0, |c.a} : c.red_b ? {5'd0, |c.b} : {3'd0, c.a | c.b};
            3'd1: return c.red_a ? {5'd0, ^c.a} : c.red_b ? {5'd0, ^c.b} : {3'd0, c.a ^ c.b};
            3'd2: return 6'(c.a) + 6'(c.b) + 6'(c.cin);
            3'd3: return 6'(c.a) * 6'(c.b);
            3'd4: return c.dir ? {prev[4:0], c.serial_in} : {c.serial_in, prev[5:1]};
            3'd5: return c.dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [15:0] drive_bits(tb_cmd_t c);
        return {c.opcode, c.a, c.b, c.cin, c.serial_in, c.red_a, c.red_b, c.byp_a, c.byp_b, c.dir};
    endfunction

    function automatic tb_cmd_t mk(int op, int a, int b, bit cin, bit ser, bit ra, bit rb,
                                   bit bpa, bit bpb, bit dir, int rep);
        tb_cmd_t c;
        c.opcode = 3'(op); c.a = 3'(a); c.b = 3'(b); c.cin = cin; c.serial_in = ser;
        c.red_a = ra; c.red_b = rb; c.byp_a = bpa; c.byp_b = bpb; c.dir = dir; c.rep = 3'(rep);
        return c;
    endfunction

    // ALSU stand-in: input register then output register, so a vector driven
    // in cycle N is visible on alsu_out during cycle N+2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_in   <= '0;
            alsu_out <= '0;
        end else begin
            env_in   <= drv_cmd;
            alsu_out <= alsu_f(env_in, alsu_out);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Commands still inside the FIFO in cycle t are those not yet taken.
    function automatic logic model_ready(int t);
        int n = 0;
        foreach (sched[i]) if (sched[i].d >= t) n++;
        return n < DEPTH;
    endfunction

    // A command can be taken once it is in the FIFO and the previous command
    // is on its last drive cycle or later; taking it exactly on that last
    // cycle chains onto the previous result, otherwise onto the parked 0.
    task automatic model_accept(input tb_cmd_t c, input int a);
        sched_t     s;
        int         steps;
        logic [5:0] v;
        s.cmd = c;
        s.d   = (a > last_drive) ? a : last_drive;
        v     = (s.d == last_drive) ? last_res : 6'd0;
        steps = (c.opcode == 3'd4 || c.opcode == 3'd5) ? int'(c.rep) + 1 : 1;
        for (int i = 0; i < steps; i++) v = alsu_f(c, v);
        s.first = s.d + 1;
        s.last  = s.d + steps;
        s.res   = v;
        s.err   = bad_encoding(c);
        sched.push_back(s);
        last_drive = s.last;
        last_res   = v;
    endtask

    task automatic checkCycle();
        logic [15:0] exp_vec;
        logic        exp_valid;
        logic [5:0]  exp_data;
        logic        exp_err;
        exp_vec = '0; exp_valid = 1'b0; exp_data = '0; exp_err = 1'b0;
        foreach (sched[i]) begin
            if (cyc >= sched[i].first && cyc <= sched[i].last) exp_vec = drive_bits(sched[i].cmd);
            if (sched[i].last + LAT + 1 == cyc) begin
                exp_valid = 1'b1;
                exp_data  = sched[i].res;
                exp_err   = sched[i].err;
            end
        end
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(model_ready(cyc)));
        checkOutput("alsu_vec", 32'(dut_vec), 32'(exp_vec));
        checkOutput("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("res_data", 32'(res_data), 32'(exp_data));
            checkOutput("res_err", 32'(res_err), 32'(exp_err));
        end
        while (sched.size() > 0 && sched[0].last + LAT + 1 <= cyc) void'(sched.pop_front());
    endtask

    task automatic tick(output bit acc);
        acc = cmd_valid && model_ready(cyc);
        @(posedge clk);
        cyc++;
        if (acc) model_accept(cur_cmd, cyc);
        #1;
        checkCycle();
    endtask

    task automatic applyStimulus(input tb_cmd_t c);
        bit acc;
        acc = 1'b0;
        cur_cmd = c;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) tick(acc);
        cmd_valid = 1'b0;
        checkOutput("accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        cmd_valid = 1'b0;
        repeat (n) tick(acc);
    endtask

    // Asserts reset between edges, checks everything went to its reset value
    // at once, then releases on a falling edge with the model emptied.
    task automatic resetAndCheck();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_alsu_vec", 32'(dut_vec), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_err", 32'(res_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        sched.delete();
        last_drive = -100;
        last_res   = '0;
        cmd_valid  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        logic [31:0] r;
        tb_cmd_t c;

        $display("[TB] power-on reset");
        resetAndCheck();

        $display("[TB] single ADD");
        applyStimulus(mk(2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        idle(6);

        $display("[TB] bypass then chained shift");
        applyStimulus(mk(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        applyStimulus(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2));
        idle(8);

        $display("[TB] fill FIFO behind a long rotate");
        applyStimulus(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
        applyStimulus(mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(2, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        idle(20);

        $display("[TB] invalid opcode then reduction OR");
        applyStimulus(mk(6, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        idle(6);

        $display("[TB] illegal reduction, idle gap, rotate of parked value");
        applyStimulus(mk(2, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        idle(3);
        applyStimulus(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle(6);

        $display("[TB] reset mid-operation");
        applyStimulus(mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 7));
        applyStimulus(mk(2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0));
        resetAndCheck();
        idle(10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            c = r[18:0];
            if ($urandom_range(0, 3) != 0) begin
                c.red_a = 1'b0;
                c.red_b = 1'b0;
            end
            if ($urandom_range(0, 3) != 0) begin
                c.byp_a = 1'b0;
                c.byp_b = 1'b0;
            end
            cur_cmd   = c;
            cmd_valid = ($urandom_range(0, 2) != 0);
            tick(acc);
        end

        cmd_valid = 1'b0;
        for (int n = 0; n < 300 && sched.size() > 0; n++) tick(acc);
        checkOutput("drained", 32'(sched.size()), 32'd0);
        idle(2);
        checkOutput("busy_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
